dec_msg_checker: RTL and testbench
==================================

# dec_msg_checker

Reads back the decrypted message that the RC4 compute stage writes into the decrypted-message memory and checks it byte by byte for a plausible plaintext. A plausible byte is lowercase ASCII 'a'..'z' (0x61–0x7A) or space (0x20). Each accepted byte is forwarded on a valid/ready stream, for example to a display or UART. The block signals done with a pass/fail verdict, which the key-search controller uses to accept the current key or advance to the next one.

## Interface
- MSG_LEN, default 32: message length in bytes; legal range 1..256.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a check; sampled only in IDLE.
- addr_to_dec_mem  out  8  read address into the decrypted-message memory.
- data_from_dec_mem  in  8  read data; valid one cycle after the address is sampled by the memory (synchronous RAM).
- out_valid  out  1  out_data holds an accepted plaintext byte.
- out_data  out  8  plaintext byte.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a check.
- pass  out  1  verdict; valid from the done pulse and held until the next accepted start.
- fail_index  out  8  index of the first rejected byte; 0 when pass=1; held like pass.

## Operation
- Index counter k is 9 bits wide, so 256 is representable. addr_to_dec_mem = k[7:0].
- Byte register b captures data_from_dec_mem.
- States:
  - IDLE: on start, clear k to 0, clear pass and fail_index, then go to READ. With no start, stay in IDLE.
  - READ: drive addr_to_dec_mem = k, then go to WAIT.
  - WAIT: hold the address; capture b <= data_from_dec_mem at the end of the cycle; go to CHECK.
  - CHECK: if b is not 0x20 and not in 0x61..0x7A, set pass<=0, fail_index<=k[7:0], go to DONE. Otherwise go to EMIT.
  - EMIT: out_valid=1, out_data=b. On handshake: if k==MSG_LEN-1, set pass<=1 and go to DONE; otherwise k<=k+1 and go to READ. Without handshake, stay in EMIT.
  - DONE: done=1 for this single cycle, then go to IDLE.
- Character checks are unsigned 8-bit comparisons. Bytes 0x00, 0x1F, 0x21, 0x60, 0x7B and 0x80..0xFF all fail.
- A rejected byte is never emitted. The bytes before it are emitted in index order.
- start is ignored in every state except IDLE, including DONE.
- The block never writes to the memory.

## Timing
- Reset values, applied asynchronously on rst: state=IDLE, k=0, b=0, addr_to_dec_mem=0, out_valid=0, out_data=0, busy=0, done=0, pass=0, fail_index=0.
- Reset mid-operation aborts immediately. The stream drops out_valid without a handshake; downstream must discard any partial message.
- out_valid and out_data are registered, or decoded from registered state and b. They are stable while out_valid=1 and out_ready=0.
- out_valid does not depend on out_ready; there is no combinational path from out_ready to out_valid.
- Per byte with out_ready held at 1: READ, WAIT, CHECK, EMIT = 4 cycles. Each cycle of backpressure adds 1 cycle.
- Counting the edge that samples start as edge 0 (READ, k=0, occupies cycle 1):
  - For a fully valid message with out_ready=1, done is high in cycle 4*MSG_LEN+1, which is cycle 129 for MSG_LEN=32.
  - If the first bad byte is at index n, done is high in cycle 4*n+4.
- busy is high from cycle 1 through the DONE cycle inclusive. busy=0 in the cycle after done.
- A new start is accepted no earlier than the cycle after DONE.

## Test plan
- All valid: memory holds "attack at dawn on the east gate " (32 bytes), out_ready=1 → 32 handshakes in order with bytes matching memory; done in cycle 129; pass=1; fail_index=0.
- Early reject: byte 5 = 0x41 ('A'), others valid → exactly 5 bytes emitted (indices 0..4); done in cycle 24; pass=0; fail_index=5; address 6 is never driven.
- Boundary characters: single-byte checks with MSG_LEN=1. Bytes 0x20, 0x61 and 0x7A → pass=1. Bytes 0x1F, 0x21, 0x60, 0x7B, 0x00 and 0xFF → pass=0, fail_index=0, no emission.
- Backpressure: out_ready random at 50% → out_data stable while stalled; byte order and count exactly match the all-valid case; done lands one cycle after the last handshake.
- Protocol abuse: start pulsed during READ, EMIT and DONE → ignored; the check runs once and produces exactly one done pulse.
- Reset mid-message: assert rst during EMIT of byte 10 → out_valid, busy and pass go to 0 immediately. A following start re-reads from address 0 and completes normally.

Source files
------------

// File: rtl/dec_msg_checker_if.sv
// Bundles the read port into the decrypted-message memory and the
// plaintext output stream of the message checker.
interface dec_msg_checker_if;
    logic [7:0] addr_to_dec_mem;
    logic [7:0] data_from_dec_mem;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output addr_to_dec_mem,
        input  data_from_dec_mem,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  addr_to_dec_mem,
        output data_from_dec_mem,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/dec_msg_checker.sv
// Reads back the RC4 decrypted message byte by byte, forwards plausible
// plaintext bytes (a..z, space) on a stream and reports a pass/fail verdict.
module dec_msg_checker #(
    parameter int MSG_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    dec_msg_checker_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           fail_index
);

    localparam logic [8:0] LAST_IDX = 9'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CHECK,
        EMIT,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] k;
    logic [7:0] b;

    function automatic logic is_plain(input logic [7:0] c);
        return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = CHECK;
            CHECK:   state_nxt = is_plain(b) ? EMIT : DONE;
            EMIT: begin
                if (bus.out_ready) begin
                    state_nxt = (k == LAST_IDX) ? DONE : READ;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The verdict registers are only cleared by an accepted start, so they
    // stay readable after done until the key-search controller moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            b          <= '0;
            pass       <= 1'b0;
            fail_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k          <= '0;
                        pass       <= 1'b0;
                        fail_index <= '0;
                    end
                end
                WAIT: b <= bus.data_from_dec_mem;
                CHECK: begin
                    if (!is_plain(b)) begin
                        pass       <= 1'b0;
                        fail_index <= k[7:0];
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (k == LAST_IDX) begin
                            pass <= 1'b1;
                        end else begin
                            k <= k + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only; out_ready never reaches out_valid.
    assign bus.addr_to_dec_mem = k[7:0];
    assign bus.out_valid       = (state == EMIT);
    assign bus.out_data        = b;
    assign busy                = (state != IDLE);
    assign done                = (state == DONE);

endmodule

// File: tb/tb_dec_msg_checker.sv
// Directed bench for dec_msg_checker: a 32-byte instance for the message
// scenarios and a 1-byte instance for the character boundary cases.
module tb_dec_msg_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic       busy, done, pass;
    logic [7:0] fail_index;
    logic       busy1, done1, pass1;
    logic [7:0] fail1;

    logic [7:0] mem  [256];
    logic [7:0] mem1 [256];

    int errors = 0;
    int checks = 0;

    int         cyc = 0;
    int         start_edge = 0;
    logic [7:0] hs_q [$];
    int         last_hs_cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    bit         addr6_seen = 0;
    int         stall_viol = 0;
    bit         prev_valid = 0;
    bit         prev_ready = 0;
    logic [7:0] prev_data = '0;

    string msg = "attack at dawn on the east gate ";

    dec_msg_checker_if bus ();
    dec_msg_checker_if bus1 ();

    dec_msg_checker #(.MSG_LEN(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_index (fail_index)
    );

    dec_msg_checker #(.MSG_LEN(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .bus        (bus1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .fail_index (fail1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus.data_from_dec_mem  <= mem[bus.addr_to_dec_mem];
        bus1.data_from_dec_mem <= mem1[bus1.addr_to_dec_mem];
    end

    // Observes the main instance mid-cycle; cycle numbers count READ of byte 0 as 1.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            hs_q.push_back(bus.out_data);
            last_hs_cyc = cyc - start_edge + 1;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc - start_edge + 1;
        end
        if (bus.addr_to_dec_mem == 8'd6) addr6_seen = 1;
        if (prev_valid && !prev_ready && (!bus.out_valid || bus.out_data !== prev_data))
            stall_viol++;
        prev_valid = bus.out_valid;
        prev_ready = bus.out_ready;
        prev_data  = bus.out_data;
    end

    task automatic load_msg();
        for (int i = 0; i < 256; i++) mem[i] = (i < 32) ? msg[i] : 8'h00;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        hs_q.delete();
        done_cnt   = 0;
        addr6_seen = 0;
        stall_viol = 0;
        prev_valid = 0;
        start_edge = cyc + 1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL wait_done: done not seen within %0d cycles (required 1 pulse)", budget);
        end
    endtask

    task automatic check_msg(input string name, input int exp_n);
        checks++;
        if (hs_q.size() !== exp_n) begin
            errors++;
            $display("FAIL %s count: got %0d handshakes, expected %0d", name, hs_q.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < hs_q.size(); i++) begin
            checks++;
            if (hs_q[i] !== msg[i]) begin
                errors++;
                $display("FAIL %s byte%0d: got %h, expected %h", name, i, hs_q[i], msg[i]);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 8;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b, expected 0", bus.out_valid); end
        if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset out_data: got %h, expected 00", bus.out_data); end
        if (bus.addr_to_dec_mem !== 8'h00) begin errors++; $display("FAIL reset addr: got %h, expected 00", bus.addr_to_dec_mem); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b, expected 0", done); end
        if (pass !== 1'b0) begin errors++; $display("FAIL reset pass: got %b, expected 0", pass); end
        if (fail_index !== 8'h00) begin errors++; $display("FAIL reset fail_index: got %h, expected 00", fail_index); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset busy1: got %b, expected 0", busy1); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_all_valid();
        load_msg();
        bus.out_ready = 1'b1;
        do_start();
        wait_done(400);
        checks += 3;
        if (done_cyc !== 129) begin errors++; $display("FAIL all_valid done_cycle: got %0d, expected 129", done_cyc); end
        if (pass !== 1'b1) begin errors++; $display("FAIL all_valid pass: got %b, expected 1", pass); end
        if (fail_index !== 8'h00) begin errors++; $display("FAIL all_valid fail_index: got %h, expected 00", fail_index); end
        check_msg("all_valid", 32);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL all_valid busy_after: got %b, expected 0", busy); end
        repeat (5) @(negedge clk);
        checks += 2;
        if (pass !== 1'b1) begin errors++; $display("FAIL all_valid pass_held: got %b, expected 1", pass); end
        if (done_cnt !== 1) begin errors++; $display("FAIL all_valid done_pulses: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_early_reject();
        load_msg();
        mem[5] = 8'h41;
        bus.out_ready = 1'b1;
        do_start();
        wait_done(400);
        checks += 4;
        if (done_cyc !== 24) begin errors++; $display("FAIL reject done_cycle: got %0d, expected 24", done_cyc); end
        if (pass !== 1'b0) begin errors++; $display("FAIL reject pass: got %b, expected 0", pass); end
        if (fail_index !== 8'd5) begin errors++; $display("FAIL reject fail_index: got %0d, expected 5", fail_index); end
        repeat (4) @(negedge clk);
        if (addr6_seen !== 1'b0) begin errors++; $display("FAIL reject addr6: got driven, expected never"); end
        check_msg("reject", 5);
    endtask

    task automatic test_boundary();
        logic [7:0] bytes [9];
        logic       exp_pass [9];
        int         emits;
        int         dones;
        bytes    = '{8'h20, 8'h61, 8'h7A, 8'h1F, 8'h21, 8'h60, 8'h7B, 8'h00, 8'hFF};
        exp_pass = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bus1.out_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            mem1[0] = bytes[t];
            @(posedge clk);
            #1;
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            emits = 0;
            dones = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (bus1.out_valid) emits++;
                if (done1) dones++;
            end
            checks += 4;
            if (pass1 !== exp_pass[t]) begin errors++; $display("FAIL boundary %h pass: got %b, expected %b", bytes[t], pass1, exp_pass[t]); end
            if (fail1 !== 8'h00) begin errors++; $display("FAIL boundary %h fail_index: got %h, expected 00", bytes[t], fail1); end
            if (emits !== (exp_pass[t] ? 1 : 0)) begin errors++; $display("FAIL boundary %h emits: got %0d, expected %0d", bytes[t], emits, exp_pass[t] ? 1 : 0); end
            if (dones !== 1) begin errors++; $display("FAIL boundary %h done_pulses: got %0d, expected 1", bytes[t], dones); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        load_msg();
        bus.out_ready = 1'b0;
        do_start();
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        bus.out_ready = 1'b1;
        checks += 4;
        if (done_cnt == 0) begin errors++; $display("FAIL backpressure timeout: done not seen in %0d cycles", n); end
        if (stall_viol !== 0) begin errors++; $display("FAIL backpressure stable: got %0d changes while stalled, expected 0", stall_viol); end
        if (done_cyc !== last_hs_cyc + 1) begin errors++; $display("FAIL backpressure done_cycle: got %0d, expected %0d", done_cyc, last_hs_cyc + 1); end
        if (pass !== 1'b1) begin errors++; $display("FAIL backpressure pass: got %b, expected 1", pass); end
        check_msg("backpressure", 32);
    endtask

    task automatic test_abuse();
        int n;
        load_msg();
        bus.out_ready = 1'b1;
        do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks += 4;
        if (done_cnt !== 1) begin errors++; $display("FAIL abuse done_pulses: got %0d, expected 1", done_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abuse busy: got %b, expected 0", busy); end
        if (pass !== 1'b1) begin errors++; $display("FAIL abuse pass: got %b, expected 1", pass); end
        if (hs_q.size() !== 32) begin errors++; $display("FAIL abuse count: got %0d, expected 32", hs_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        load_msg();
        bus.out_ready = 1'b1;
        do_start();
        n = 0;
        while (!(bus.out_valid && hs_q.size() == 11) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(bus.out_valid && hs_q.size() == 11)) begin
            errors++;
            $display("FAIL reset_mid reach_byte10: got %0d handshakes, expected EMIT of byte 10", hs_q.size());
        end
        rst = 1'b1;
        #1;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid out_valid: got %b, expected 0", bus.out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b, expected 0", busy); end
        if (pass !== 1'b0) begin errors++; $display("FAIL reset_mid pass: got %b, expected 0", pass); end
        if (bus.addr_to_dec_mem !== 8'h00) begin errors++; $display("FAIL reset_mid addr: got %h, expected 00", bus.addr_to_dec_mem); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_start();
        wait_done(400);
        checks += 2;
        if (done_cyc !== 129) begin errors++; $display("FAIL reset_mid done_cycle: got %0d, expected 129", done_cyc); end
        if (pass !== 1'b1) begin errors++; $display("FAIL reset_mid pass_after: got %b, expected 1", pass); end
        check_msg("reset_mid", 32);
    endtask

    initial begin
        bus.out_ready  = 1'b1;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'h00;
            mem1[i] = 8'h00;
        end
        test_reset();
        test_all_valid();
        test_early_reject();
        test_boundary();
        test_backpressure();
        test_abuse();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
